// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared front-end definitions for the instruction fetch path.
package inst_fetch_ctrl_pkg;

  localparam logic [31:0] FS_RESET_PC   = 32'h1c00_0000;
  localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;
  localparam logic [31:0] FETCH_STEP    = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_buf.sv
// One-entry PC+instruction buffer holding a returned fetch while IF is stalled.
module inst_fetch_ctrl_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        vld_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        vld_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end else if (clear_i || flush_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-request controller: one outstanding read on the SRAM-like bus,
// stale-response discard after redirects, one-entry stall buffer.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FS_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  input  logic        fs_allowin,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        to_fs_valid,
  output logic [31:0] to_fs_pc,
  output logic [31:0] to_fs_inst
);

  fetch_state_e state_q;
  logic [31:0]  req_pc_q;
  logic [31:0]  pend_pc_q;
  logic         pend_vld_q;
  logic         discard_q;

  logic         resp_ok;
  logic         deliver_now;
  logic         buf_load;
  logic         buf_clear;
  logic         buf_flush;
  logic         buf_vld;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_inst;

  // A response is usable only if it is live and no redirect kills it this cycle.
  assign resp_ok     = (state_q == S_WAIT) && inst_sram_data_ok && !discard_q && !br_taken_cancel;
  assign deliver_now = resp_ok && fs_allowin;
  assign buf_load    = resp_ok && !fs_allowin;
  assign buf_clear   = (state_q == S_HOLD) && fs_allowin;
  assign buf_flush   = (state_q == S_HOLD) && br_taken_cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_pc_q   <= RESET_PC;
      pend_pc_q  <= '0;
      pend_vld_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          if (br_taken_cancel) req_pc_q <= br_target;
        end
        S_REQ: begin
          if (br_taken_cancel) begin
            pend_pc_q  <= br_target;
            pend_vld_q <= 1'b1;
          end
          if (inst_sram_addr_ok) begin
            state_q   <= S_WAIT;
            discard_q <= pend_vld_q || br_taken_cancel;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            state_q    <= S_REQ;
            pend_vld_q <= 1'b0;
            discard_q  <= 1'b0;
            // A same-cycle redirect is newer than any pending target.
            if (br_taken_cancel)  req_pc_q <= br_target;
            else if (discard_q)   req_pc_q <= pend_pc_q;
            else if (fs_allowin)  req_pc_q <= req_pc_q + FETCH_STEP;
            else                  state_q  <= S_HOLD;
          end else if (br_taken_cancel) begin
            discard_q  <= 1'b1;
            pend_pc_q  <= br_target;
            pend_vld_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (br_taken_cancel) begin
            state_q  <= S_REQ;
            req_pc_q <= br_target;
          end else if (fs_allowin) begin
            state_q  <= S_REQ;
            req_pc_q <= req_pc_q + FETCH_STEP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  inst_fetch_ctrl_fetch_buf u_fetch_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .flush_i (buf_flush),
    .pc_i    (req_pc_q),
    .inst_i  (inst_sram_rdata),
    .vld_o   (buf_vld),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );

  assign inst_sram_req   = (state_q == S_REQ);
  assign inst_sram_addr  = req_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;

  assign to_fs_valid = deliver_now || (buf_vld && !br_taken_cancel);
  assign to_fs_pc    = deliver_now ? req_pc_q        : buf_pc;
  assign to_fs_inst  = deliver_now ? inst_sram_rdata : buf_inst;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; bus handshakes are driven cycle by cycle.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic        fs_allowin;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        to_fs_valid;
  logic [31:0] to_fs_pc;
  logic [31:0] to_fs_inst;

  int unsigned n_checks;
  int unsigned n_fails;

  inst_fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .br_taken_cancel   (br_taken_cancel),
    .br_target         (br_target),
    .fs_allowin        (fs_allowin),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .to_fs_valid       (to_fs_valid),
    .to_fs_pc          (to_fs_pc),
    .to_fs_inst        (to_fs_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; pulse inputs return to 0, fs_allowin is sticky.
  task automatic tick();
    @(posedge clk);
    #1;
    br_taken_cancel   = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_taken_cancel = 1'b1;
    br_target       = tgt;
  endtask

  // Three reset cycles, one IDLE cycle checked, returns in the first REQ cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    settle();
    chk("rst_req", {31'd0, inst_sram_req}, 32'd0);
    chk("rst_valid", {31'd0, to_fs_valid}, 32'd0);
    reset = 1'b0;
    settle();
    chk("idle_req", {31'd0, inst_sram_req}, 32'd0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    br_taken_cancel = 1'b0;
    br_target = '0;
    fs_allowin = 1'b1;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0;

    // Reset and first fetch with 0-wait memory.
    do_reset();
    chk("rst_fs_pc", to_fs_pc, 32'd0);
    chk("rst_fs_inst", to_fs_inst, 32'd0);
    chk("tie_wr", {31'd0, inst_sram_wr}, 32'd0);
    chk("tie_size", {30'd0, inst_sram_size}, 32'd2);
    chk("tie_wstrb", {28'd0, inst_sram_wstrb}, 32'd0);
    chk("tie_wdata", inst_sram_wdata, 32'd0);
    inst_sram_addr_ok = 1'b1;
    settle();
    chk("first_req", {31'd0, inst_sram_req}, 32'd1);
    chk("first_addr", inst_sram_addr, 32'h1c00_0000);
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h0280_0000;
    settle();
    chk("first_req_wait", {31'd0, inst_sram_req}, 32'd0);
    chk("first_valid", {31'd0, to_fs_valid}, 32'd1);
    chk("first_pc", to_fs_pc, 32'h1c00_0000);
    chk("first_inst", to_fs_inst, 32'h0280_0000);
    tick();
    settle();
    chk("next_addr", inst_sram_addr, 32'h1c00_0004);
    chk("next_req", {31'd0, inst_sram_req}, 32'd1);

    // Address stability with addr_ok withheld, redirect in the second cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) redirect(32'h1c00_0100);
      settle();
      chk("stable_req", {31'd0, inst_sram_req}, 32'd1);
      chk("stable_addr", inst_sram_addr, 32'h1c00_0000);
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    settle();
    chk("accept_addr", inst_sram_addr, 32'h1c00_0000);
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hdead_beef;
    settle();
    chk("stale_drop", {31'd0, to_fs_valid}, 32'd0);
    tick();
    settle();
    chk("redir_req", {31'd0, inst_sram_req}, 32'd1);
    chk("redir_addr", inst_sram_addr, 32'h1c00_0100);

    // Redirect while waiting for data; data_ok three cycles later.
    inst_sram_addr_ok = 1'b1;
    tick();
    redirect(32'h1c00_0200);
    settle();
    chk("wait_redir_valid", {31'd0, to_fs_valid}, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("wait_no_req", {31'd0, inst_sram_req}, 32'd0);
      tick();
    end
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h0000_1111;
    settle();
    chk("wait_old_drop", {31'd0, to_fs_valid}, 32'd0);
    tick();
    settle();
    chk("wait_redir_addr", inst_sram_addr, 32'h1c00_0200);
    chk("wait_redir_req", {31'd0, inst_sram_req}, 32'd1);

    // Stall: fs_allowin low for 5 cycles starting at data_ok.
    inst_sram_addr_ok = 1'b1;
    tick();
    fs_allowin        = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h1111_1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("hold_valid", {31'd0, to_fs_valid}, 32'd1);
      chk("hold_pc", to_fs_pc, 32'h1c00_0200);
      chk("hold_inst", to_fs_inst, 32'h1111_1111);
      chk("hold_no_req", {31'd0, inst_sram_req}, 32'd0);
      tick();
    end
    fs_allowin = 1'b1;
    settle();
    chk("hold_release_valid", {31'd0, to_fs_valid}, 32'd1);
    chk("hold_release_inst", to_fs_inst, 32'h1111_1111);
    chk("hold_release_noreq", {31'd0, inst_sram_req}, 32'd0);
    tick();
    settle();
    chk("after_hold_req", {31'd0, inst_sram_req}, 32'd1);
    chk("after_hold_addr", inst_sram_addr, 32'h1c00_0204);

    // Redirect with data_ok, then redirect during HOLD.
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h2222_0000;
    redirect(32'h1c00_0300);
    settle();
    chk("simul_drop", {31'd0, to_fs_valid}, 32'd0);
    tick();
    settle();
    chk("simul_addr", inst_sram_addr, 32'h1c00_0300);
    chk("simul_req", {31'd0, inst_sram_req}, 32'd1);
    inst_sram_addr_ok = 1'b1;
    tick();
    fs_allowin        = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h2222_2222;
    tick();
    settle();
    chk("hold2_valid", {31'd0, to_fs_valid}, 32'd1);
    chk("hold2_pc", to_fs_pc, 32'h1c00_0300);
    tick();
    fs_allowin = 1'b1;
    redirect(32'h1c00_0400);
    settle();
    chk("hold_redir_drop", {31'd0, to_fs_valid}, 32'd0);
    tick();
    settle();
    chk("hold_redir_addr", inst_sram_addr, 32'h1c00_0400);
    chk("hold_redir_req", {31'd0, inst_sram_req}, 32'd1);
    chk("hold_redir_noval", {31'd0, to_fs_valid}, 32'd0);

    // Wrap-around of req_pc.
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b1;
    redirect(32'hffff_fffc);
    tick();
    settle();
    chk("wrap_addr0", inst_sram_addr, 32'hffff_fffc);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h3333_3333;
    settle();
    chk("wrap_valid", {31'd0, to_fs_valid}, 32'd1);
    chk("wrap_pc", to_fs_pc, 32'hffff_fffc);
    chk("wrap_inst", to_fs_inst, 32'h3333_3333);
    tick();
    settle();
    chk("wrap_addr1", inst_sram_addr, 32'h0000_0000);

    // Reset in WAIT, stray data_ok right after.
    inst_sram_addr_ok = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h4444_4444;
    settle();
    chk("stray_valid", {31'd0, to_fs_valid}, 32'd0);
    chk("stray_req", {31'd0, inst_sram_req}, 32'd0);
    tick();
    inst_sram_data_ok = 1'b1;
    settle();
    chk("restart_req", {31'd0, inst_sram_req}, 32'd1);
    chk("restart_addr", inst_sram_addr, 32'h1c00_0000);
    chk("restart_stray", {31'd0, to_fs_valid}, 32'd0);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h0280_0000;
    settle();
    chk("restart_valid", {31'd0, to_fs_valid}, 32'd1);
    chk("restart_pc", to_fs_pc, 32'h1c00_0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
